// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : io_pkg
//  Purpose  : Definitions shared by the I/O peripherals on the shared bus.
//             It holds the bus command encodings, the default register
//             addresses, the status/clear bit positions and the receiver
//             state type.
//  Revision : 1.0 - initial release
// ============================================================================
package io_pkg;

  // Bus command encodings
  localparam logic [1:0] BUS_CMD_READ    = 2'b00;
  localparam logic [1:0] BUS_CMD_WRITE   = 2'b01;
  localparam logic [1:0] BUS_CMD_READ_B  = 2'b10;
  localparam logic [1:0] BUS_CMD_WRITE_B = 2'b11;

  // Default register byte addresses
  localparam logic [15:0] IO_DATA_ADDR   = 16'h0002;
  localparam logic [15:0] IO_STATUS_ADDR = 16'h0004;

  // Bit positions of the fields in the status read value
  localparam int STAT_AVAIL_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVR_BIT   = 2;
  localparam int STAT_FERR_BIT  = 3;

  // Write-one-to-clear positions in the status write data.
  // These positions are not the same as the read positions.
  localparam int CLR_OVR_BIT  = 1;
  localparam int CLR_FERR_BIT = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/io_uart_rx_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : Receives 8N1 serial data. The input passes through a 2-flop
//             synchronizer. A deserializer FSM then takes the synchronized
//             line and produces the received byte.
//  Ports    : clk, reset   - clock and synchronous active-high reset
//             i_rxp        - serial input, idle high
//             o_byte       - received byte, valid while o_valid is high
//             o_valid      - 1-clk pulse when a frame has a good stop bit
//             o_ferr       - 1-clk pulse when a frame has a bad stop bit
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx
  import io_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rxp,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_ferr
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DIV - 1);

  rx_state_t        r_state;
  logic             r_sync1, r_sync2, r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RX_IDLE;
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      o_byte  <= '0;
      o_valid <= 1'b0;
      o_ferr  <= 1'b0;
    end else begin
      r_sync1 <= i_rxp;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      o_valid <= 1'b0;
      o_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (r_prev && !r_sync2) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          // Check the start bit at its middle. A line that has gone high
          // again by then was a glitch.
          if (r_cnt == C_HALF) begin
            r_cnt <= '0;
            r_bit <= '0;
            r_state <= r_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (r_cnt == C_FULL) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};  // LSB arrives first
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (r_cnt == C_FULL) begin
            r_cnt <= '0;
            if (r_sync2) begin
              o_byte  <= r_shift;
              o_valid <= 1'b1;
              r_state <= RX_IDLE;
            end else begin
              // Bad stop bit. Do not look for a new start edge until the
              // line is high again.
              o_ferr  <= 1'b1;
              r_state <= RX_WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RX_WAIT_HIGH: begin
          if (r_sync2) r_state <= RX_IDLE;
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/io_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : io_uart_rx
//  Purpose  : UART receive peripheral that responds on the shared bus.
//             Received bytes are stored in a FIFO. Data reads return and pop
//             the head byte. The status register gives {ferr, ovr, full,
//             avail}. Writing ones to the status register clears the sticky
//             error bits.
//  Ports    : clk, reset             - clock, synchronous active-high reset
//             addr, cmd, wr_data     - bus request
//             run / done             - request / completion toggles
//             rd_data                - read data
//             uart_rxp               - serial input, idle high
//  Config   : IO_UART_RX_BLOCKING_EN - when defined, a data read on an empty
//             FIFO stalls until a byte arrives. When undefined, such a read
//             completes at once with 16'h8000.
//  Revision : 1.0 - initial release
// ============================================================================
module io_uart_rx
  import io_pkg::*;
#(
  parameter int          CLK_FREQ    = 27000000,
  parameter int          BAUD        = 115200,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DATA_ADDR   = IO_DATA_ADDR,
  parameter logic [15:0] STATUS_ADDR = IO_STATUS_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [1:0]  cmd,
  input  logic        run,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        done,
  input  logic        uart_rxp
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;

  logic [7:0]  w_rx_byte;
  logic        w_rx_valid, w_rx_ferr;

  uart_rx #(.DIV(DIV)) u_rx (
    .clk     (clk),
    .reset   (reset),
    .i_rxp   (uart_rxp),
    .o_byte  (w_rx_byte),
    .o_valid (w_rx_valid),
    .o_ferr  (w_rx_ferr)
  );

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic        r_ovr, r_ferr;

  logic        w_empty, w_full, w_pend, w_is_rd, w_is_wr, w_is_data, w_is_stat;
  logic        w_pop, w_push, w_ovr_evt, w_complete;
  logic [15:0] w_clr, w_rd_next;
  logic        w_unused;

  // The MSBs differ and the index bits match only when the FIFO is full.
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);

  assign w_pend    = run ^ done;
  assign w_is_rd   = (cmd == BUS_CMD_READ)  || (cmd == BUS_CMD_READ_B);
  assign w_is_wr   = (cmd == BUS_CMD_WRITE) || (cmd == BUS_CMD_WRITE_B);
  assign w_is_data = (addr == DATA_ADDR);
  assign w_is_stat = (addr == STATUS_ADDR);

  assign w_pop     = w_pend && w_is_rd && w_is_data && !w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // still succeeds.
  assign w_push    = w_rx_valid && (!w_full || w_pop);
  assign w_ovr_evt = w_rx_valid && w_full && !w_pop;
  assign w_clr     = (w_pend && w_is_wr && w_is_stat) ? wr_data : 16'h0000;

`ifdef IO_UART_RX_BLOCKING_EN
  // Leave the request pending. A later cycle completes it as a normal pop.
  assign w_complete = w_pend && !(w_is_rd && w_is_data && w_empty);
`else
  assign w_complete = w_pend;
`endif

  always_comb begin
    w_rd_next = 16'h0000;
    if (w_is_data) begin
      w_rd_next = w_empty ? 16'h8000 : {8'h00, r_mem[r_rp[AW-1:0]]};
    end else if (w_is_stat) begin
      w_rd_next[STAT_FERR_BIT]  = r_ferr;
      w_rd_next[STAT_OVR_BIT]   = r_ovr;
      w_rd_next[STAT_FULL_BIT]  = w_full;
      w_rd_next[STAT_AVAIL_BIT] = !w_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= w_rx_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done    <= 1'b0;
      rd_data <= 16'h0000;
      r_wp    <= '0;
      r_rp    <= '0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_complete) begin
        done <= ~done;
        if (w_is_rd) rd_data <= w_rd_next;
      end
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      // If a clear and a new error event happen in the same cycle, the
      // error event wins.
      r_ovr  <= (r_ovr  & ~w_clr[CLR_OVR_BIT])  | w_ovr_evt;
      r_ferr <= (r_ferr & ~w_clr[CLR_FERR_BIT]) | w_rx_ferr;
    end
  end

  assign w_unused = ^{wr_data[15:3], wr_data[0]};

endmodule
`default_nettype wire
